// File: rtl/cpu1_pkg.sv
// Shared definitions for the cpu1 core: sequencer state encoding and the
// default interrupt vector address.
package cpu1_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam int unsigned IRQ_VECTOR_DEFAULT = 1;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: reti return address, then branch target, then the
// sequential increment (wraps modulo 2^WIDTH).
module pc_next_sel #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             reti_req,
   input  logic             branch_req,
   input  logic [WIDTH-1:0] pc_q,
   input  logic [WIDTH-1:0] epc,
   input  logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] npc,
   output logic             jump
);

   always_comb begin
      jump = reti_req | branch_req;
      if (reti_req)
         npc = epc;
      else if (branch_req)
         npc = branch_target;
      else
         npc = pc_q + WIDTH'(1);
   end

endmodule

// File: rtl/pc_seq.sv
// Instruction-fetch sequencer for cpu1: drives the PC register strobes, the
// fetch/execute handshake, branches, single-level interrupts and halt/wake.
module pc_seq
   import cpu1_pkg::*;
#(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(IRQ_VECTOR_DEFAULT)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pc_q,
   output logic             pc_cen,
   output logic             pc_wen,
   output logic [WIDTH-1:0] pc_din,
   output logic             fetch_req,
   input  logic             mem_ready,
   output logic             ir_load,
   input  logic             branch_req,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             halt_req,
   input  logic             reti_req,
   input  logic             ei_req,
   input  logic             di_req,
   input  logic             irq,
   output logic             irq_ack,
   output logic [WIDTH-1:0] epc,
   output logic             ie,
   output logic             halted
);

   state_t           state, state_d;
   logic             ie_d;
   logic [WIDTH-1:0] epc_d;
   logic [WIDTH-1:0] npc;
   logic             jump;

   pc_next_sel #(.WIDTH(WIDTH)) u_next (
      .reti_req      (reti_req),
      .branch_req    (branch_req),
      .pc_q          (pc_q),
      .epc           (epc),
      .branch_target (branch_target),
      .npc           (npc),
      .jump          (jump)
   );

   // Outputs are gated by reset_n so every strobe drops as soon as reset is
   // asserted, not just once the state register has been cleared.
   always_comb begin
      state_d   = state;
      ie_d      = ie;
      epc_d     = epc;
      pc_cen    = 1'b0;
      pc_wen    = 1'b0;
      pc_din    = '0;
      fetch_req = 1'b0;
      ir_load   = 1'b0;
      irq_ack   = 1'b0;
      halted    = 1'b0;
      if (reset_n) begin
         case (state)
            FETCH: begin
               fetch_req = 1'b1;
               if (mem_ready) begin
                  ir_load = 1'b1;
                  state_d = EXEC;
               end
            end
            EXEC: begin
               if (irq && ie && !reti_req) begin
                  // Interrupt entry wins over halt; the halt is simply dropped.
                  epc_d   = npc;
                  ie_d    = 1'b0;
                  pc_wen  = 1'b1;
                  pc_din  = IRQ_VECTOR;
                  irq_ack = 1'b1;
                  state_d = FETCH;
               end else begin
                  if (jump) begin
                     pc_wen = 1'b1;
                     pc_din = npc;
                  end else begin
                     pc_cen = 1'b1;
                  end
                  if (reti_req)
                     ie_d = 1'b1;
                  else if (di_req)
                     ie_d = 1'b0;
                  else if (ei_req)
                     ie_d = 1'b1;
                  state_d = halt_req ? HALT : FETCH;
               end
            end
            HALT: begin
               halted = 1'b1;
               if (irq) begin
                  epc_d   = pc_q;
                  ie_d    = 1'b0;
                  pc_wen  = 1'b1;
                  pc_din  = IRQ_VECTOR;
                  irq_ack = 1'b1;
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= FETCH;
         ie    <= 1'b0;
         epc   <= '0;
      end else begin
         state <= state_d;
         ie    <= ie_d;
         epc   <= epc_d;
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: a cycle-by-cycle vector table walked from reset,
// followed by a hand-written asynchronous reset sequence mid-FETCH.
module tb_pc_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc_q;
   logic        pc_cen, pc_wen;
   logic [31:0] pc_din;
   logic        fetch_req, mem_ready, ir_load;
   logic        branch_req;
   logic [31:0] branch_target;
   logic        halt_req, reti_req, ei_req, di_req;
   logic        irq, irq_ack;
   logic [31:0] epc;
   logic        ie, halted;

   int unsigned tests = 0;
   int unsigned fails = 0;

   pc_seq #(.WIDTH(32), .IRQ_VECTOR(32'd1)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc_q          (pc_q),
      .pc_cen        (pc_cen),
      .pc_wen        (pc_wen),
      .pc_din        (pc_din),
      .fetch_req     (fetch_req),
      .mem_ready     (mem_ready),
      .ir_load       (ir_load),
      .branch_req    (branch_req),
      .branch_target (branch_target),
      .halt_req      (halt_req),
      .reti_req      (reti_req),
      .ei_req        (ei_req),
      .di_req        (di_req),
      .irq           (irq),
      .irq_ack       (irq_ack),
      .epc           (epc),
      .ie            (ie),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // strb = {halt, reti, ei, di}; ex = {fetch_req, ir_load, pc_cen, pc_wen, irq_ack, halted, ie}
   typedef struct {
      logic        mr;
      logic [31:0] pcq;
      logic        br;
      logic [31:0] bt;
      logic [3:0]  strb;
      logic        irq;
      logic [6:0]  ex;
      logic [31:0] din;
      logic [31:0] epc;
   } vec_t;

   vec_t tbl[35];

   function automatic vec_t mk(input logic mr, input logic [31:0] pcq, input logic br,
                               input logic [31:0] bt, input logic [3:0] strb, input logic irq,
                               input logic [6:0] ex, input logic [31:0] din, input logic [31:0] e);
      vec_t v;
      v.mr = mr; v.pcq = pcq; v.br = br; v.bt = bt; v.strb = strb;
      v.irq = irq; v.ex = ex; v.din = din; v.epc = e;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s [vec %0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      mem_ready     = v.mr;
      pc_q          = v.pcq;
      branch_req    = v.br;
      branch_target = v.bt;
      {halt_req, reti_req, ei_req, di_req} = v.strb;
      irq           = v.irq;
   endtask

   initial begin
      // Sequential run from pc 5
      tbl[0]  = mk(1, 32'd5,        0, 0,       4'b0000, 0, 7'b1100000, 0,      0);
      tbl[1]  = mk(0, 32'd5,        0, 0,       4'b0000, 0, 7'b0010000, 0,      0);
      tbl[2]  = mk(1, 32'd6,        0, 0,       4'b0000, 0, 7'b1100000, 0,      0);
      tbl[3]  = mk(0, 32'd6,        0, 0,       4'b0000, 0, 7'b0010000, 0,      0);
      // Memory wait: three not-ready cycles then ready
      tbl[4]  = mk(0, 32'd7,        0, 0,       4'b0000, 0, 7'b1000000, 0,      0);
      tbl[5]  = mk(0, 32'd7,        0, 0,       4'b0000, 0, 7'b1000000, 0,      0);
      tbl[6]  = mk(0, 32'd7,        0, 0,       4'b0000, 0, 7'b1000000, 0,      0);
      tbl[7]  = mk(1, 32'd7,        0, 0,       4'b0000, 0, 7'b1100000, 0,      0);
      // Branch to 0x100
      tbl[8]  = mk(0, 32'd7,        1, 32'h100, 4'b0000, 0, 7'b0001000, 32'h100, 0);
      tbl[9]  = mk(1, 32'h100,      0, 0,       4'b0000, 0, 7'b1100000, 0,      0);
      // Sequential at all-ones with ei
      tbl[10] = mk(0, 32'hFFFFFFFF, 0, 0,       4'b0010, 0, 7'b0010000, 0,      0);
      tbl[11] = mk(1, 32'd0,        0, 0,       4'b0000, 0, 7'b1100001, 0,      0);
      // Interrupt at pc 0x20
      tbl[12] = mk(0, 32'h20,       0, 0,       4'b0000, 1, 7'b0001101, 32'd1,  0);
      tbl[13] = mk(1, 32'd1,        0, 0,       4'b0000, 0, 7'b1100000, 0,      32'h21);
      // reti returns to 0x21 and re-enables
      tbl[14] = mk(0, 32'd1,        0, 0,       4'b0100, 0, 7'b0001000, 32'h21, 32'h21);
      tbl[15] = mk(1, 32'h21,       0, 0,       4'b0000, 0, 7'b1100001, 0,      32'h21);
      // Interrupt at all-ones: saved npc wraps to 0
      tbl[16] = mk(0, 32'hFFFFFFFF, 0, 0,       4'b0000, 1, 7'b0001101, 32'd1,  32'h21);
      tbl[17] = mk(1, 32'd1,        0, 0,       4'b0000, 0, 7'b1100000, 0,      0);
      // ei+di together: di wins; irq ignored with ie=0
      tbl[18] = mk(0, 32'd2,        0, 0,       4'b0011, 1, 7'b0010000, 0,      0);
      tbl[19] = mk(1, 32'd3,        0, 0,       4'b0000, 0, 7'b1100000, 0,      0);
      tbl[20] = mk(0, 32'd3,        0, 0,       4'b0010, 0, 7'b0010000, 0,      0);
      // Strobes and irq ignored in FETCH
      tbl[21] = mk(1, 32'd4,        0, 0,       4'b1000, 1, 7'b1100001, 0,      0);
      // irq outranks halt
      tbl[22] = mk(0, 32'd4,        0, 0,       4'b1000, 1, 7'b0001101, 32'd1,  0);
      tbl[23] = mk(1, 32'd1,        0, 0,       4'b0000, 0, 7'b1100000, 0,      32'd5);
      // Halt at pc 7, wake by irq with ie=0
      tbl[24] = mk(0, 32'd7,        0, 0,       4'b1000, 0, 7'b0010000, 0,      32'd5);
      tbl[25] = mk(0, 32'd8,        0, 0,       4'b0000, 0, 7'b0000010, 0,      32'd5);
      tbl[26] = mk(1, 32'd8,        0, 0,       4'b0110, 0, 7'b0000010, 0,      32'd5);
      tbl[27] = mk(0, 32'd8,        0, 0,       4'b0000, 1, 7'b0001110, 32'd1,  32'd5);
      tbl[28] = mk(0, 32'd1,        0, 0,       4'b0000, 0, 7'b1000000, 0,      32'd8);
      tbl[29] = mk(1, 32'd1,        0, 0,       4'b0000, 0, 7'b1100000, 0,      32'd8);
      tbl[30] = mk(0, 32'd9,        0, 0,       4'b0010, 0, 7'b0010000, 0,      32'd8);
      tbl[31] = mk(1, 32'hA,        0, 0,       4'b0000, 0, 7'b1100001, 0,      32'd8);
      // reti beats branch and suppresses a pending irq
      tbl[32] = mk(0, 32'h40,       1, 32'h77,  4'b0100, 1, 7'b0001001, 32'd8,  32'd8);
      tbl[33] = mk(1, 32'd8,        0, 0,       4'b0000, 0, 7'b1100001, 0,      32'd8);
      tbl[34] = mk(0, 32'd8,        0, 0,       4'b0000, 0, 7'b0010001, 0,      32'd8);

      reset_n = 1'b0;
      drive(mk(0, 0, 0, 0, 4'b0000, 0, 7'b0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      chk("reset_fetch_req", -1, {31'd0, fetch_req}, 32'd0);
      chk("reset_ie",        -1, {31'd0, ie},        32'd0);
      chk("reset_epc",       -1, epc,                32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 35; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk("fetch_req", i, {31'd0, fetch_req}, {31'd0, tbl[i].ex[6]});
         chk("ir_load",   i, {31'd0, ir_load},   {31'd0, tbl[i].ex[5]});
         chk("pc_cen",    i, {31'd0, pc_cen},    {31'd0, tbl[i].ex[4]});
         chk("pc_wen",    i, {31'd0, pc_wen},    {31'd0, tbl[i].ex[3]});
         chk("irq_ack",   i, {31'd0, irq_ack},   {31'd0, tbl[i].ex[2]});
         chk("halted",    i, {31'd0, halted},    {31'd0, tbl[i].ex[1]});
         chk("ie",        i, {31'd0, ie},        {31'd0, tbl[i].ex[0]});
         chk("pc_din",    i, pc_din,             tbl[i].din);
         chk("epc",       i, epc,                tbl[i].epc);
         chk("cen_wen_excl", i, {31'd0, pc_cen & pc_wen}, 32'd0);
         @(posedge clk);
         #1;
      end

      // Asynchronous reset while waiting in FETCH (ie=1, epc=8 beforehand)
      drive(mk(0, 32'd9, 0, 0, 4'b0000, 0, 7'b0, 0, 0));
      #1;
      chk("pre_rst_fetch_req", 100, {31'd0, fetch_req}, 32'd1);
      chk("pre_rst_ie",        100, {31'd0, ie},        32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_fetch_req", 101, {31'd0, fetch_req}, 32'd0);
      chk("rst_strobes",   101, {27'd0, ir_load, pc_cen, pc_wen, irq_ack, halted}, 32'd0);
      chk("rst_pc_din",    101, pc_din, 32'd0);
      chk("rst_ie",        101, {31'd0, ie}, 32'd0);
      chk("rst_epc",       101, epc, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_fetch_req", 102, {31'd0, fetch_req}, 32'd1);
      chk("post_rst_ir_load",   102, {31'd0, ir_load},   32'd0);
      mem_ready = 1'b1;
      #1;
      chk("post_rst_ir_load_rdy", 103, {31'd0, ir_load}, 32'd1);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_exec_cen", 104, {31'd0, pc_cen}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
